dmem_arbiter: RTL and testbench

// Shares the single-port data memory (DMEM) between the CPU control path and a host loader/debug port.

---
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 tb/tb_dmem_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port DMEM between the CPU and a host port,
// with a host exclusive lock guarded by a watchdog that forces release after LOCK_MAX cycles.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LOCK_MAX   = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic                  host_lock,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  locked,
  output logic                  lock_err
);

  typedef enum logic [1:0] {ARB, LOCKED, HOLDOFF} state_t;
  typedef enum logic {LAST_CPU, LAST_HOST} last_t;

  localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);

  state_t     state_reg;
  last_t      last_grant_reg;
  logic [7:0] lock_cnt_reg;
  logic       lock_err_reg;
  logic       cpu_rvalid_reg;
  logic       host_rvalid_reg;

  // While locked the CPU is shut out and the host is served only while it keeps the lock.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (!rst) begin
      if (state_reg == LOCKED) begin
        host_gnt = host_req & host_lock;
      end else if (cpu_req && host_req) begin
        cpu_gnt  = (last_grant_reg == LAST_HOST);
        host_gnt = (last_grant_reg == LAST_CPU);
      end else begin
        cpu_gnt  = cpu_req;
        host_gnt = host_req;
      end
    end
  end

  always_comb begin
    mem_en    = cpu_gnt | host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // Registered state is masked during reset so every output reads 0 in the reset cycle.
  assign cpu_rvalid  = cpu_rvalid_reg & ~rst;
  assign host_rvalid = host_rvalid_reg & ~rst;
  assign locked      = (state_reg == LOCKED) & ~rst;
  assign lock_err    = lock_err_reg & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ARB;
      last_grant_reg  <= LAST_HOST;
      lock_cnt_reg    <= 8'd0;
      lock_err_reg    <= 1'b0;
      cpu_rvalid_reg  <= 1'b0;
      host_rvalid_reg <= 1'b0;
    end else begin
      cpu_rvalid_reg  <= cpu_gnt & ~cpu_we;
      host_rvalid_reg <= host_gnt & ~host_we;
      if (cpu_gnt)  last_grant_reg <= LAST_CPU;
      if (host_gnt) last_grant_reg <= LAST_HOST;
      case (state_reg)
        ARB: begin
          if (host_gnt && host_lock) begin
            state_reg    <= LOCKED;
            lock_cnt_reg <= 8'd0;
          end
        end
        LOCKED: begin
          if (!host_lock) begin
            state_reg      <= ARB;
            last_grant_reg <= LAST_HOST;
          end else if (lock_cnt_reg == CNT_LAST) begin
            state_reg      <= HOLDOFF;
            lock_err_reg   <= 1'b1;
            last_grant_reg <= LAST_HOST;
          end else begin
            lock_cnt_reg <= lock_cnt_reg + 8'd1;
          end
        end
        HOLDOFF: begin
          if (!host_lock) state_reg <= ARB;
        end
        default: state_reg <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter: round-robin grants, read returns, host lock,
// watchdog release and reset behaviour, with hand-computed expectations.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata;
  logic        mem_en, mem_we, locked, lock_err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .LOCK_MAX(200)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .locked(locked), .lock_err(lock_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and checked mid-cycle.
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_lock = 0;
  endtask

  task automatic do_reset();
    go(); rst = 1; idle_inputs(); settle();
    go(); rst = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnts"}, {30'd0, cpu_gnt, host_gnt}, 32'd0);
    chk({tag, "_rvalids"}, {30'd0, cpu_rvalid, host_rvalid}, 32'd0);
    chk({tag, "_mem"}, {mem_en, mem_we, mem_addr, mem_wdata}, 32'd0);
    chk({tag, "_lock"}, {30'd0, locked, lock_err}, 32'd0);
  endtask

  initial begin
    int lock_cycles;
    int cpu_leak;
    rst = 1; idle_inputs();

    // Reset cycle with live requests: every output must read 0.
    go(); cpu_req = 1; host_req = 1; host_lock = 1; cpu_addr = 8'h44; host_addr = 8'h55;
    settle(); chk_all_zero("reset");
    $display("[TB] reset with requests pending: outputs zero");
    go(); rst = 0; idle_inputs();

    // 1: lone CPU read, rvalid one cycle later only.
    cpu_req = 1; cpu_addr = 8'h10; settle();
    chk("t1_cpu_gnt", cpu_gnt, 1); chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_addr", mem_addr, 8'h10); chk("t1_host_gnt", host_gnt, 0);
    chk("t1_rvalid_same", cpu_rvalid, 0);
    go(); idle_inputs(); settle();
    chk("t1_rvalid_next", cpu_rvalid, 1); chk("t1_idle_mem_en", mem_en, 0);
    chk("t1_idle_addr", mem_addr, 0);
    go(); settle(); chk("t1_rvalid_gone", cpu_rvalid, 0);
    $display("[TB] cpu read addr=0x10 granted, rvalid next cycle");

    // 2: both requesting after reset alternate CPU, HOST, CPU, HOST.
    do_reset();
    cpu_req = 1; cpu_addr = 8'h11; host_req = 1; host_addr = 8'h22;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("t2_cpu_gnt_%0d", i), cpu_gnt, (i % 2 == 0));
      chk($sformatf("t2_host_gnt_%0d", i), host_gnt, (i % 2 == 1));
      chk($sformatf("t2_addr_%0d", i), mem_addr, (i % 2 == 0) ? 8'h11 : 8'h22);
      if (i > 0) chk($sformatf("t2_rvalid_%0d", i), {cpu_rvalid, host_rvalid},
                     (i % 2 == 1) ? 2'b10 : 2'b01);
      $display("[TB] contention cycle %0d: cpu_gnt=%0b host_gnt=%0b addr=0x%0h",
               i, cpu_gnt, host_gnt, mem_addr);
      go();
    end
    idle_inputs();

    // 6: host write, no read return.
    host_req = 1; host_we = 1; host_addr = 8'h3F; host_wdata = 16'hBEEF; settle();
    chk("t6_host_gnt", host_gnt, 1); chk("t6_mem_we", mem_we, 1);
    chk("t6_mem_wdata", mem_wdata, 16'hBEEF); chk("t6_mem_addr", mem_addr, 8'h3F);
    go(); idle_inputs(); settle();
    chk("t6_no_rvalid", host_rvalid, 0);
    $display("[TB] host write 0x3F<=0xBEEF");

    // 3: lock blocks the CPU until released, then one idle cycle, then CPU.
    do_reset();
    cpu_req = 1; cpu_addr = 8'h01; host_req = 1; host_lock = 1; host_addr = 8'h02; settle();
    chk("t3_first_cpu", cpu_gnt, 1);
    go(); settle();
    chk("t3_host_gnt", host_gnt, 1); chk("t3_not_locked_yet", locked, 0);
    for (int i = 0; i < 3; i++) begin
      go(); settle();
      chk($sformatf("t3_locked_%0d", i), {locked, cpu_gnt, host_gnt}, 3'b101);
    end
    go(); host_lock = 0; settle();
    chk("t3_release_idle", {locked, cpu_gnt, host_gnt, mem_en}, 4'b1000);
    go(); settle();
    chk("t3_after_unlock", {locked, cpu_gnt, host_gnt}, 3'b010);
    chk("t3_no_err", lock_err, 0);
    $display("[TB] host lock held then released, cpu resumes");

    // 4: watchdog forces release after 200 LOCKED cycles.
    do_reset();
    cpu_req = 1; host_req = 1; host_lock = 1; cpu_addr = 8'hA0; host_addr = 8'hB0; settle();
    chk("t4_first_cpu", cpu_gnt, 1);
    go(); settle(); chk("t4_lock_gnt", host_gnt, 1);
    lock_cycles = 0; cpu_leak = 0;
    go(); settle();
    while (locked === 1'b1 && lock_cycles < 300) begin
      lock_cycles++;
      if (cpu_gnt !== 1'b0 || host_gnt !== 1'b1) cpu_leak++;
      go(); settle();
    end
    chk("t4_lock_cycles", lock_cycles, 200);
    chk("t4_lock_grants", cpu_leak, 0);
    chk("t4_lock_err", lock_err, 1);
    chk("t4_holdoff_cpu", {locked, cpu_gnt, host_gnt}, 3'b010);
    for (int i = 0; i < 4; i++) begin
      go(); settle();
      chk($sformatf("t4_alt_%0d", i), {locked, cpu_gnt, host_gnt},
          (i % 2 == 0) ? 3'b001 : 3'b010);
    end
    go(); host_lock = 0; settle();
    chk("t4_err_sticky", lock_err, 1);
    $display("[TB] watchdog release after %0d locked cycles, lock_err=%0b", lock_cycles, lock_err);

    // 5: reset right after a host read drops the pending return.
    do_reset();
    host_req = 1; host_addr = 8'h33; settle();
    chk("t5_host_gnt", host_gnt, 1);
    go(); rst = 1; cpu_req = 1; settle();
    chk_all_zero("t5_rst");
    go(); rst = 0; settle();
    chk("t5_no_rvalid", host_rvalid, 0);
    chk("t5_cpu_first", {cpu_gnt, host_gnt}, 2'b10);
    $display("[TB] reset after host read: rvalid dropped, cpu wins first tie");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
